// File: rtl/key_scan_ctrl_if.sv
// Key scanner signal bundle: mode/raw keys in, tick, events, toggles and busy out.
interface key_scan_ctrl_if #(
   parameter int N_KEYS = 4
);
   logic [1:0]        MODE;
   logic [N_KEYS-1:0] S_IN;
   logic              CE_OUT;
   logic [N_KEYS-1:0] KEY_OUT;
   logic [N_KEYS-1:0] TOGGLE;
   logic              BUSY;

   modport master (
      output MODE, S_IN,
      input  CE_OUT, KEY_OUT, TOGGLE, BUSY
   );

   modport slave (
      input  MODE, S_IN,
      output CE_OUT, KEY_OUT, TOGGLE, BUSY
   );
endinterface

// File: rtl/key_scan_ctrl.sv
// Debounced key scanner: prescaled sampling tick, per-key shift debounce and a
// single-owner FSM providing single, toggle, repeat and delayed-repeat events.
module key_scan_ctrl #(
   parameter int N_KEYS = 4,
   parameter int PRESC  = 1000,
   parameter int L_BIT  = 4,
   parameter int DELAY  = 8,
   parameter int RATE   = 3
) (
   input logic            CLK,
   input logic            CLR,
   key_scan_ctrl_if.slave bus
);
   localparam int PW   = $clog2(PRESC);
   localparam int OW   = $clog2(N_KEYS);
   localparam int MAXT = (DELAY > RATE) ? DELAY : RATE;
   localparam int CW   = $clog2(MAXT + 1);

   typedef enum logic [1:0] {IDLE, HELD, WAIT, REPEAT} state_t;

   state_t                       state;
   logic [PW-1:0]                presc_cnt;
   logic [CW-1:0]                tick_cnt;
   logic [N_KEYS-1:0][L_BIT-1:0] shreg;
   logic [N_KEYS-1:0][L_BIT-1:0] shreg_next;
   logic [N_KEYS-1:0]            held_next;
   logic [N_KEYS-1:0]            held_prev;
   logic [N_KEYS-1:0]            press;
   logic [OW-1:0]                owner;
   logic [OW-1:0]                grant_idx;
   logic [N_KEYS-1:0]            key_out;
   logic [N_KEYS-1:0]            toggle;
   logic                         ce;

   assign ce = (presc_cnt == PW'(PRESC - 1));

   // held_next is the debounced level this tick will commit; only meaningful when ce is high.
   // NOTE: grant_idx is defaulted before the priority loop so no latch is inferred.
   always_comb begin
      grant_idx = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         shreg_next[k] = {shreg[k][L_BIT-2:0], bus.S_IN[k]};
         held_next[k]  = &shreg_next[k];
         held_prev[k]  = &shreg[k];
      end
      press = held_next & ~held_prev;
      for (int k = N_KEYS - 1; k >= 0; k--) begin
         if (press[k]) grant_idx = OW'(k);
      end
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         // NOTE: the debounce array is a bank of plain flops, so it is cleared with everything else.
         state     <= IDLE;
         presc_cnt <= '0;
         tick_cnt  <= '0;
         shreg     <= '0;
         owner     <= '0;
         key_out   <= '0;
         toggle    <= '0;
      end else begin
         // NOTE: non-blocking throughout; the default low makes every key_out pulse one CLK wide.
         key_out   <= '0;
         presc_cnt <= ce ? '0 : presc_cnt + 1'b1;
         if (ce) begin
            shreg <= shreg_next;
            if (state == IDLE) begin
               if (|press) begin
                  owner              <= grant_idx;
                  key_out[grant_idx] <= 1'b1;
                  tick_cnt           <= '0;
                  case (bus.MODE)
                     2'b00: state <= HELD;
                     2'b01: begin
                        toggle[grant_idx] <= ~toggle[grant_idx];
                        state             <= HELD;
                     end
                     2'b10:   state <= REPEAT;
                     default: state <= WAIT;
                  endcase
               end
            end else if (!held_next[owner]) begin
               // Release wins over a repeat falling due on the same tick.
               state    <= IDLE;
               tick_cnt <= '0;
            end else if (state == WAIT) begin
               if (tick_cnt == CW'(DELAY - 1)) begin
                  key_out[owner] <= 1'b1;
                  tick_cnt       <= '0;
                  state          <= REPEAT;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end else if (state == REPEAT) begin
               if (tick_cnt == CW'(RATE - 1)) begin
                  key_out[owner] <= 1'b1;
                  tick_cnt       <= '0;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign bus.CE_OUT  = ce;
   assign bus.KEY_OUT = key_out;
   assign bus.TOGGLE  = toggle;
   assign bus.BUSY    = (state != IDLE);
endmodule

// File: tb/tb_key_scan_ctrl.sv
// Scoreboard bench for key_scan_ctrl: expected key pulses are queued with the
// cycle they must appear in and matched by a negedge monitor.
module tb_key_scan_ctrl;
   localparam int N_KEYS = 4;
   localparam int PRESC  = 4;
   localparam int L_BIT  = 4;
   localparam int DELAY  = 3;
   localparam int RATE   = 2;

   typedef struct {
      int key;
      int cyc;
   } pulse_t;

   logic   CLK = 1'b0;
   logic   CLR = 1'b1;
   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 1;
   pulse_t exp_q[$];

   key_scan_ctrl_if #(.N_KEYS(N_KEYS)) bus ();

   key_scan_ctrl #(
      .N_KEYS(N_KEYS),
      .PRESC (PRESC),
      .L_BIT (L_BIT),
      .DELAY (DELAY),
      .RATE  (RATE)
   ) dut (
      .CLK(CLK),
      .CLR(CLR),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   // cyc = k during the k-th cycle after CLR falls; tick t is cycle t*PRESC.
   always @(posedge CLK) begin
      if (CLR) cyc <= 1;
      else     cyc <= cyc + 1;
   end

   always @(negedge CLK) begin
      if (bus.KEY_OUT != '0) begin
         pulse_t            e;
         logic [N_KEYS-1:0] want;
         n_tests++;
         if ($countones(bus.KEY_OUT) != 1) begin
            n_fail++;
            $display("FAIL key_onehot: KEY_OUT=%b at cycle %0d, required a single bit", bus.KEY_OUT, cyc);
         end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL key_unexpected: KEY_OUT=%b at cycle %0d, required no pulse", bus.KEY_OUT, cyc);
         end else begin
            e          = exp_q.pop_front();
            want       = '0;
            want[e.key] = 1'b1;
            if (bus.KEY_OUT !== want || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL key_pulse: KEY_OUT=%b at cycle %0d, required %b at cycle %0d",
                        bus.KEY_OUT, cyc, want, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void expect_pulse(int key, int tick);
      exp_q.push_back('{key: key, cyc: tick * PRESC + 1});
   endfunction

   task automatic wait_cyc(int c);
      while (cyc < c) @(negedge CLK);
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      CLR      = 1'b1;
      bus.S_IN = '0;
      repeat (2) @(negedge CLK);
      CLR = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_tests++;
      if (bus.BUSY !== 1'b0 || bus.KEY_OUT !== '0 || bus.TOGGLE !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: BUSY=%b KEY_OUT=%b TOGGLE=%b, required 0 0000 0000",
                  bus.BUSY, bus.KEY_OUT, bus.TOGGLE);
      end
      bus.MODE = 2'b01;
      bus.S_IN = 4'b1000;
      expect_pulse(3, 4);
      wait_cyc(5 * PRESC + 1);
      bus.S_IN = '0;
      n_tests++;
      if (bus.TOGGLE !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_pre_toggle: TOGGLE=%b, required 1000", bus.TOGGLE);
      end
      wait_cyc(6 * PRESC + 1);
      bus.MODE = 2'b10;
      bus.S_IN = 4'b0001;
      expect_pulse(0, 10);
      expect_pulse(0, 12);
      expect_pulse(0, 14);
      wait_cyc(58);
      n_tests++;
      if (bus.BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_busy: BUSY=%b, required 1", bus.BUSY);
      end
      wait_cyc(59);
      CLR      = 1'b1;
      bus.S_IN = '0;
      @(negedge CLK);
      n_tests++;
      if (bus.KEY_OUT !== '0 || bus.TOGGLE !== '0 || bus.BUSY !== 1'b0 || bus.CE_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_repeat: KEY_OUT=%b TOGGLE=%b BUSY=%b CE_OUT=%b, required 0000 0000 0 0",
                  bus.KEY_OUT, bus.TOGGLE, bus.BUSY, bus.CE_OUT);
      end
      @(negedge CLK);
      CLR = 1'b0;
      for (int c = 1; c <= PRESC; c++) begin
         logic want_ce;
         wait_cyc(c);
         want_ce = (c == PRESC);
         n_tests++;
         if (bus.CE_OUT !== want_ce) begin
            n_fail++;
            $display("FAIL reset_first_ce: CE_OUT=%b in cycle %0d, required %b", bus.CE_OUT, c, want_ce);
         end
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL reset_drain: %0d pulses missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_single();
      apply_reset();
      bus.MODE = 2'b00;
      bus.S_IN = 4'b0011;
      expect_pulse(0, 4);
      wait_cyc(3 * PRESC + 1);
      bus.S_IN[1] = 1'b0;
      wait_cyc(5 * PRESC + 1);
      n_tests++;
      if (bus.BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy: BUSY=%b, required 1", bus.BUSY);
      end
      bus.MODE = 2'b10;
      wait_cyc(12 * PRESC + 1);
      bus.S_IN = '0;
      wait_cyc(13 * PRESC + 2);
      n_tests++;
      if (bus.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: BUSY=%b, required 0", bus.BUSY);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL single_drain: %0d pulses missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_toggle();
      apply_reset();
      bus.MODE = 2'b01;
      bus.S_IN = 4'b0100;
      expect_pulse(2, 4);
      wait_cyc(5 * PRESC + 1);
      bus.S_IN = '0;
      n_tests++;
      if (bus.TOGGLE !== 4'b0100) begin
         n_fail++;
         $display("FAIL toggle_first: TOGGLE=%b, required 0100", bus.TOGGLE);
      end
      wait_cyc(7 * PRESC + 1);
      bus.S_IN = 4'b0100;
      expect_pulse(2, 11);
      wait_cyc(12 * PRESC + 1);
      bus.S_IN = '0;
      n_tests++;
      if (bus.TOGGLE !== 4'b0000) begin
         n_fail++;
         $display("FAIL toggle_second: TOGGLE=%b, required 0000", bus.TOGGLE);
      end
      wait_cyc(14 * PRESC + 1);
      n_tests++;
      if (bus.BUSY !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL toggle_end: BUSY=%b pending=%0d, required 0 0", bus.BUSY, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_repeat();
      for (int m = 2; m <= 3; m++) begin
         apply_reset();
         bus.MODE = 2'(m);
         bus.S_IN = 4'b0001;
         if (m == 2) begin
            expect_pulse(0, 4);
            expect_pulse(0, 6);
            expect_pulse(0, 8);
            expect_pulse(0, 10);
         end else begin
            expect_pulse(0, 4);
            expect_pulse(0, 7);
            expect_pulse(0, 9);
            expect_pulse(0, 11);
         end
         wait_cyc(11 * PRESC + 1);
         bus.S_IN = '0;
         wait_cyc(16 * PRESC + 1);
         n_tests++;
         if (bus.BUSY !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_mode%0d_end: BUSY=%b pending=%0d, required 0 0", m, bus.BUSY, exp_q.size());
            exp_q.delete();
         end
      end
   endtask

   task automatic test_priority();
      apply_reset();
      bus.MODE = 2'b00;
      bus.S_IN = 4'b1010;
      expect_pulse(1, 4);
      wait_cyc(5 * PRESC + 1);
      n_tests++;
      if (bus.BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL priority_busy: BUSY=%b, required 1", bus.BUSY);
      end
      wait_cyc(6 * PRESC + 1);
      bus.S_IN = 4'b1000;
      wait_cyc(8 * PRESC + 1);
      n_tests++;
      if (bus.BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL priority_release: BUSY=%b, required 0", bus.BUSY);
      end
      wait_cyc(12 * PRESC + 1);
      n_tests++;
      if (bus.BUSY !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL priority_no_regrant: BUSY=%b pending=%0d, required 0 0", bus.BUSY, exp_q.size());
         exp_q.delete();
      end
      bus.S_IN = '0;
   endtask

   initial begin
      bus.MODE = 2'b00;
      bus.S_IN = '0;
      test_reset();
      test_single();
      test_toggle();
      test_repeat();
      test_priority();
      repeat (4) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/key_scan_ctrl.md
KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of raw key inputs (2..8).
REQ-002 SHALL have parameter PRESC, default 1000, CLK cycles per sampling tick (>=2).
REQ-003 SHALL have parameter L_BIT, default 4, debounce shift length in ticks (>=2).
REQ-004 SHALL have parameter DELAY, default 8, ticks before first auto-repeat (>=1).
REQ-005 SHALL have parameter RATE, default 3, ticks between auto-repeats (>=1).
REQ-006 SHALL have port CLK, input, 1, sole clock; all logic on rising edge.
REQ-007 SHALL have port CLR, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port MODE, input, 2, key behaviour: 00 single, 01 toggle, 10 repeat, 11 delayed repeat.
REQ-009 SHALL have port S_IN, input, N_KEYS, raw active-high key levels, already synchronous to CLK.
REQ-010 SHALL have port CE_OUT, output, 1, sampling tick, one CLK wide.
REQ-011 SHALL have port KEY_OUT, output, N_KEYS, one-CLK key event pulses, registered.
REQ-012 SHALL have port TOGGLE, output, N_KEYS, per-key toggle levels, registered.
REQ-013 SHALL have port BUSY, output, 1, high while a key owns the controller.

Function
REQ-014 SHALL run a prescaler 0..PRESC-1, wrapping; CE_OUT high exactly when it equals PRESC-1.
REQ-015 SHALL keep one L_BIT shift register per key, shifting S_IN[k] in at LSB only on CE_OUT cycles.
REQ-016 SHALL treat key k as held when its shift register is all ones; press edge = held now, not held before this tick.
REQ-017 SHALL run FSM IDLE, HELD, WAIT, REPEAT; BUSY = (state != IDLE).
REQ-018 SHALL, in IDLE on a press edge, grant the lowest-index pressing key as owner, pulse KEY_OUT[owner] on the next CLK.
REQ-019 SHALL sample MODE only at grant; MODE changes while BUSY have no effect until next grant.
REQ-020 SHALL on grant: mode 00 -> HELD; mode 01 -> invert TOGGLE[owner], HELD; mode 10 -> REPEAT; mode 11 -> WAIT.
REQ-021 SHALL in WAIT count ticks; on the DELAY-th tick pulse KEY_OUT[owner] next CLK, clear count, enter REPEAT.
REQ-022 SHALL in REPEAT count ticks; on every RATE-th tick pulse KEY_OUT[owner] next CLK, clear count.
REQ-023 SHALL return to IDLE, clear tick count, emit no pulse, when the owner stops being held, from any non-IDLE state.
REQ-024 SHALL ignore press edges of non-owner keys while BUSY (no pulse, no toggle, not queued).
REQ-025 SHALL require a fresh press edge for grant: key still held when owner releases is never granted.
REQ-026 SHALL give release priority over repeat if both occur on the same tick (no pulse).
REQ-027 SHALL never assert more than one KEY_OUT bit in any cycle.

Reset
REQ-028 SHALL, while CLR high, set prescaler, shift registers, tick counter, KEY_OUT, TOGGLE to 0, CE_OUT 0, state IDLE; CLR overrides all other activity including mid-repeat.
REQ-029 SHALL assert first CE_OUT in the PRESC-th cycle after CLR falls.

Verification (bench params PRESC=4, L_BIT=4, DELAY=3, RATE=2, ticks numbered from CLR release)
REQ-030 SHALL cover: CLR mid-REPEAT for 2 cycles -> all outputs 0, BUSY 0, CE_OUT first at 4th cycle after release.
REQ-031 SHALL cover: MODE=00, S_IN[0] high from tick 0 for 12 ticks -> single KEY_OUT[0] pulse one CLK after tick 4; S_IN[1] high only 3 ticks -> no pulse.
REQ-032 SHALL cover: MODE=01, key 2 pressed/released twice -> TOGGLE[2] 0->1->0, two pulses.
REQ-033 SHALL cover: MODE=10, key 0 held ticks 1..11 -> pulses after ticks 4,6,8,10; release at 11 -> no further pulse; MODE=11 same -> pulses after 4,7,9,11.
REQ-034 SHALL cover: keys 1 and 3 press edges on same tick -> only KEY_OUT[1]; release key 1 while key 3 held -> no KEY_OUT[3], BUSY 0.
